// File: rtl/wb_mem_ic_pkg.sv
// Shared types and constants for the Wishbone memory interconnect.
// The FSM encoding, the slave limit and the watchdog sizing live here.
package wb_mem_ic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int          MAX_SLAVES       = 4;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // The watchdog counts 0..TIMEOUT-1; a disabled watchdog (TIMEOUT=0) still needs one bit.
    function automatic int wdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_mem_addr_decode.sv
// Combinational address-window match for up to four memory slaves.
// Windows are compared in 33 bits; on overlap the lowest index wins.
module wb_mem_addr_decode
    import wb_mem_ic_pkg::*;
#(
    parameter int          NUM_SLAVES   = 2,
    parameter logic [31:0] MEM_OFFSET_0 = 32'h0000_0000,
    parameter logic [31:0] MEM_OFFSET_1 = 32'h0080_0000,
    parameter logic [31:0] MEM_OFFSET_2 = 32'h0100_0000,
    parameter logic [31:0] MEM_OFFSET_3 = 32'h0180_0000,
    parameter logic [31:0] MEM_SIZE_0   = 32'h0080_0000,
    parameter logic [31:0] MEM_SIZE_1   = 32'h0080_0000,
    parameter logic [31:0] MEM_SIZE_2   = 32'h0080_0000,
    parameter logic [31:0] MEM_SIZE_3   = 32'h0080_0000
) (
    input  logic [31:0] adr_i,
    output logic        hit_o,
    output logic [1:0]  idx_o
);

    localparam logic [31:0] OFFSETS [MAX_SLAVES] = '{MEM_OFFSET_0, MEM_OFFSET_1, MEM_OFFSET_2, MEM_OFFSET_3};
    localparam logic [31:0] SIZES   [MAX_SLAVES] = '{MEM_SIZE_0, MEM_SIZE_1, MEM_SIZE_2, MEM_SIZE_3};

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (({1'b0, adr_i} >= {1'b0, OFFSETS[k]}) &&
                ({1'b0, adr_i} <  ({1'b0, OFFSETS[k]} + {1'b0, SIZES[k]}))) begin
                hit_o = 1'b1;
                idx_o = 2'(k);
            end
        end
    end

endmodule

// File: rtl/wishbone_mem_interconnect_n.sv
// Wishbone classic interconnect: one master to 1..4 memory slaves, with registered
// response, bus error on unmapped addresses and a per-transfer watchdog.
module wishbone_mem_interconnect_n
    import wb_mem_ic_pkg::*;
#(
    parameter int          NUM_SLAVES   = 2,
    parameter logic [31:0] MEM_OFFSET_0 = 32'h0000_0000,
    parameter logic [31:0] MEM_OFFSET_1 = 32'h0080_0000,
    parameter logic [31:0] MEM_OFFSET_2 = 32'h0100_0000,
    parameter logic [31:0] MEM_OFFSET_3 = 32'h0180_0000,
    parameter logic [31:0] MEM_SIZE_0   = 32'h0080_0000,
    parameter logic [31:0] MEM_SIZE_1   = 32'h0080_0000,
    parameter logic [31:0] MEM_SIZE_2   = 32'h0080_0000,
    parameter logic [31:0] MEM_SIZE_3   = 32'h0080_0000,
    parameter int          ADR_RELATIVE = 1,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = DEFAULT_ERR_DATA
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_m_we,
    input  logic                       i_m_stb,
    input  logic                       i_m_cyc,
    input  logic [3:0]                 i_m_sel,
    input  logic [31:0]                i_m_adr,
    input  logic [31:0]                i_m_dat,
    output logic [31:0]                o_m_dat,
    output logic                       o_m_ack,
    output logic                       o_m_err,
    output logic                       o_m_int,
    output logic [NUM_SLAVES-1:0]      o_s_we,
    output logic [NUM_SLAVES-1:0]      o_s_cyc,
    output logic [NUM_SLAVES-1:0]      o_s_stb,
    output logic [3:0]                 o_s_sel,
    output logic [31:0]                o_s_adr,
    output logic [31:0]                o_s_dat,
    input  logic [NUM_SLAVES-1:0]      i_s_ack,
    input  logic [32*NUM_SLAVES-1:0]   i_s_dat,
    input  logic [NUM_SLAVES-1:0]      i_s_int
);

    localparam int              WD_W    = wdog_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
    localparam logic [31:0]     OFFSETS [MAX_SLAVES] = '{MEM_OFFSET_0, MEM_OFFSET_1, MEM_OFFSET_2, MEM_OFFSET_3};

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       dat_q, dat_d;
    logic              int_q;

    logic              hit;
    logic [1:0]        hit_idx;
    logic              slv_ack;
    logic [31:0]       slv_dat;
    logic              wdog_expired;

    wb_mem_addr_decode #(
        .NUM_SLAVES   (NUM_SLAVES),
        .MEM_OFFSET_0 (MEM_OFFSET_0),
        .MEM_OFFSET_1 (MEM_OFFSET_1),
        .MEM_OFFSET_2 (MEM_OFFSET_2),
        .MEM_OFFSET_3 (MEM_OFFSET_3),
        .MEM_SIZE_0   (MEM_SIZE_0),
        .MEM_SIZE_1   (MEM_SIZE_1),
        .MEM_SIZE_2   (MEM_SIZE_2),
        .MEM_SIZE_3   (MEM_SIZE_3)
    ) u_decode (
        .adr_i (i_m_adr),
        .hit_o (hit),
        .idx_o (hit_idx)
    );

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        slv_ack = 1'b0;
        slv_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == 2'(k)) begin
                slv_ack = i_s_ack[k];
                slv_dat = i_s_dat[32*k +: 32];
            end
        end
    end

    // Only the selected slave sees the master's handshake, and only while ACTIVE.
    always_comb begin
        o_s_cyc = '0;
        o_s_stb = '0;
        o_s_we  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if ((state_q == ACTIVE) && (sel_q == 2'(k))) begin
                o_s_cyc[k] = i_m_cyc;
                o_s_stb[k] = i_m_stb;
                o_s_we[k]  = i_m_we;
            end
        end
    end

    assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdog_d  = wdog_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        adr_d   = (ADR_RELATIVE != 0) ? (i_m_adr - OFFSETS[hit_idx]) : i_m_adr;
                        wdog_d  = '0;
                        state_d = ACTIVE;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dat_d   = ERR_DATA;
                        state_d = RESP;
                    end
                end
            end
            ACTIVE: begin
                // Slave ack is checked before the watchdog so a same-cycle ack is never lost.
                if (!i_m_cyc) begin
                    state_d = IDLE;
                end else if (slv_ack) begin
                    ack_d   = 1'b1;
                    dat_d   = slv_dat;
                    state_d = RESP;
                end else if (wdog_expired) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    dat_d   = ERR_DATA;
                    state_d = RESP;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            adr_q   <= '0;
            wdog_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdog_q  <= wdog_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            int_q   <= |i_s_int;
        end
    end

    assign o_m_ack = ack_q;
    assign o_m_err = err_q;
    assign o_m_dat = dat_q;
    assign o_m_int = int_q;
    assign o_s_sel = i_m_sel;
    assign o_s_adr = adr_q;
    assign o_s_dat = i_m_dat;

endmodule

// File: tb/tb_wishbone_mem_interconnect_n.sv
// Directed bench for wishbone_mem_interconnect_n: stimulus queues expected responses,
// a monitor pops and compares them whenever the DUT acks the master.
module tb_wishbone_mem_interconnect_n;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_we, m_stb, m_cyc;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_wdat;
    logic [31:0] m_rdat;
    logic        m_ack, m_err, m_int;
    logic [1:0]  s_we, s_cyc, s_stb, s_ack, s_int;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [31:0] s_dat0, s_dat1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_cnt  = 0;
    int   lat  [2] = '{0, 0};
    int   scnt [2] = '{0, 0};
    exp_t sb [$];

    wishbone_mem_interconnect_n #(
        .NUM_SLAVES (2),
        .TIMEOUT    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_m_we  (m_we),
        .i_m_stb (m_stb),
        .i_m_cyc (m_cyc),
        .i_m_sel (m_sel),
        .i_m_adr (m_adr),
        .i_m_dat (m_wdat),
        .o_m_dat (m_rdat),
        .o_m_ack (m_ack),
        .o_m_err (m_err),
        .o_m_int (m_int),
        .o_s_we  (s_we),
        .o_s_cyc (s_cyc),
        .o_s_stb (s_stb),
        .o_s_sel (s_sel),
        .o_s_adr (s_adr),
        .o_s_dat (s_wdat),
        .i_s_ack (s_ack),
        .i_s_dat ({s_dat1, s_dat0}),
        .i_s_int (s_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave model: ack on the lat-th consecutive strobe cycle; lat=0 never acks.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) scnt[k] <= s_stb[k] ? scnt[k] + 1 : 0;
    end

    always_comb begin
        s_ack = '0;
        for (int k = 0; k < 2; k++)
            s_ack[k] = s_stb[k] && (lat[k] != 0) && (scnt[k] == lat[k] - 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every master ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && m_ack) begin
            check("ack_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("ack_dat", m_rdat, e.dat);
                check("ack_err", 32'(m_err), 32'(e.err));
                check("ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
            end
        end
        if (!rst && m_err && !m_ack) check("err_with_ack", 32'(m_ack), 32'd1);
    end

    // delay: cycles from the stb-issue edge to the cycle in which o_m_ack is visible.
    task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic expect_resp,
                         input logic [31:0] exp_dat, input logic exp_err, input int delay);
        @(posedge clk);
        #1;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_we   = we;
        m_adr  = adr;
        m_wdat = dat;
        m_sel  = sel;
        if (expect_resp) sb.push_back(exp_t'{dat: exp_dat, err: exp_err, cyc: cyc_cnt + delay});
    endtask

    task automatic finish_xfer();
        int n;
        n = 0;
        while (!m_ack && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ack_arrived", 32'(m_ack), 32'd1);
        @(posedge clk);
        #1;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        m_we = 0; m_stb = 0; m_cyc = 0; m_sel = '0; m_adr = '0; m_wdat = '0;
        s_int = '0;
        s_dat0 = 32'h0BAD_F00D;
        s_dat1 = 32'h1234_5678;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(m_ack), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_int", 32'(m_int), 32'd0);
        check("rst_dat", m_rdat, 32'd0);
        check("rst_stb", 32'(s_stb), 32'd0);
        check("rst_cyc", 32'(s_cyc), 32'd0);
        rst = 1'b0;

        // Read slave 1 at relative address 0x10, slave latency 3
        lat[1] = 3;
        start(1'b0, 32'h0080_0010, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0, 4);
        @(posedge clk); @(negedge clk);
        check("rd1_stb", 32'(s_stb), 32'b10);
        check("rd1_cyc", 32'(s_cyc), 32'b10);
        check("rd1_adr", s_adr, 32'h0000_0010);
        finish_xfer();

        // Write slave 0, latency 1: broadcast data/sel and per-slave we
        lat[0] = 1;
        start(1'b1, 32'h0000_0100, 32'hCAFE_BABE, 4'b0011, 1'b1, 32'h0BAD_F00D, 1'b0, 2);
        @(posedge clk); @(negedge clk);
        check("wr0_we", 32'(s_we), 32'b01);
        check("wr0_dat", s_wdat, 32'hCAFE_BABE);
        check("wr0_sel", 32'(s_sel), 32'b0011);
        check("wr0_adr", s_adr, 32'h0000_0100);
        finish_xfer();

        // Unmapped with two slaves populated
        start(1'b1, 32'h0100_0000, 32'h5555_AAAA, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1);
        @(posedge clk); @(negedge clk);
        check("unmap_stb", 32'(s_stb), 32'b00);
        finish_xfer();

        // Last word of window 1
        lat[1] = 1;
        start(1'b0, 32'h00FF_FFFC, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0, 2);
        @(posedge clk); @(negedge clk);
        check("edge_adr", s_adr, 32'h007F_FFFC);
        check("edge_stb", 32'(s_stb), 32'b10);
        finish_xfer();

        // Watchdog: slave 0 never acks, TIMEOUT=8
        lat[0] = 0;
        start(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1, 9);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_stb[0]) cnt++;
            if (m_ack) break;
        end
        check("wd_stb_cycles", 32'(cnt), 32'd8);
        finish_xfer();

        // Slave ack coincides with watchdog expiry: ack wins
        lat[0] = 8;
        start(1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 32'h0BAD_F00D, 1'b0, 9);
        finish_xfer();

        // Abort: master drops cyc in the second ACTIVE cycle
        lat[1] = 0;
        start(1'b0, 32'h0080_0020, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 0);
        @(posedge clk); @(negedge clk);
        check("abort_stb_before", 32'(s_stb), 32'b10);
        @(posedge clk);
        #1;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        #1;
        check("abort_stb_drop", 32'(s_stb), 32'b00);
        check("abort_cyc_drop", 32'(s_cyc), 32'b00);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m_ack) cnt++;
        end
        check("abort_no_ack", 32'(cnt), 32'd0);

        // Transfer after abort decodes normally
        lat[1] = 2;
        s_dat1 = 32'hCAFE_0001;
        start(1'b0, 32'h0080_0044, 32'h0, 4'hF, 1'b1, 32'hCAFE_0001, 1'b0, 3);
        @(posedge clk); @(negedge clk);
        check("post_abort_adr", s_adr, 32'h0000_0044);
        finish_xfer();

        // Async reset in the middle of ACTIVE
        s_int = 2'b01;
        lat[0] = 0;
        start(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 0);
        @(posedge clk); @(negedge clk);
        check("mid_stb", 32'(s_stb), 32'b01);
        check("mid_int", 32'(m_int), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_stb", 32'(s_stb), 32'b00);
        check("arst_cyc", 32'(s_cyc), 32'b00);
        check("arst_dat", m_rdat, 32'd0);
        check("arst_int", 32'(m_int), 32'd0);
        check("arst_ack", 32'(m_ack), 32'd0);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        s_int = 2'b10;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("int_pre_edge", 32'(m_int), 32'd0);
        @(posedge clk);
        #1;
        check("int_one_cycle", 32'(m_int), 32'd1);
        s_int = 2'b00;

        // Recovery read after reset
        lat[0] = 2;
        start(1'b0, 32'h0000_0008, 32'h0, 4'hF, 1'b1, 32'h0BAD_F00D, 1'b0, 3);
        finish_xfer();

        repeat (4) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wishbone_mem_interconnect_n.md
Name: wishbone_mem_interconnect_n

Overview:
- Parametrised Wishbone classic memory interconnect: one master fans out to 1..4 memory slaves.
- Each slave has its own base/size window.
- Adds features over a single-slave pass-through:
  - slave select registered per transfer;
  - optional base-relative slave addressing;
  - registered master ack/data;
  - bus-error response for unmapped addresses;
  - per-transfer watchdog timeout.
- Sits between the host bus master and the memory-side peripherals (SDRAM, BRAM, PPFIFO bridges).

Parameters:
- NUM_SLAVES, 2, number of populated slaves, legal 1..4.
- MEM_OFFSET_0..MEM_OFFSET_3, 0 / 32'h0080_0000 / 32'h0100_0000 / 32'h0180_0000, byte base of each window.
- MEM_SIZE_0..MEM_SIZE_3, 32'h0080_0000 each, window size. A size of 0 disables that window.
- ADR_RELATIVE, 1, 1 = slave sees i_m_adr minus its offset; 0 = slave sees i_m_adr unchanged.
- TIMEOUT, 255, cycles in ACTIVE without slave ack before bus error. 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, value returned on o_m_dat with o_m_err.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_m_we  in  1  master write enable
- i_m_stb  in  1  master strobe
- i_m_cyc  in  1  master cycle
- i_m_sel  in  4  master byte select
- i_m_adr  in  32  master address
- i_m_dat  in  32  master write data
- o_m_dat  out  32  read data to master (registered)
- o_m_ack  out  1  ack to master (registered, 1-cycle pulse)
- o_m_err  out  1  bus-error qualifier, high only together with o_m_ack
- o_m_int  out  1  registered OR of i_s_int[NUM_SLAVES-1:0]
- o_s_we  out  NUM_SLAVES  per-slave write enable
- o_s_cyc  out  NUM_SLAVES  per-slave cycle
- o_s_stb  out  NUM_SLAVES  per-slave strobe
- o_s_sel  out  4  byte select, broadcast
- o_s_adr  out  32  address, broadcast (offset-adjusted per ADR_RELATIVE)
- o_s_dat  out  32  write data, broadcast
- i_s_ack  in  NUM_SLAVES  per-slave ack
- i_s_dat  in  32*NUM_SLAVES  per-slave read data; slave k on bits [32k+31:32k]
- i_s_int  in  NUM_SLAVES  per-slave interrupt

Behaviour:
- Reset (async, rst=1): state IDLE; o_m_ack, o_m_err, o_m_int = 0; o_m_dat = 0; o_s_cyc, o_s_stb, o_s_we = 0; sel_idx = 0; watchdog = 0.
- Decode (combinational): hit_k = (adr >= OFFSET_k) && ({1'b0,adr} < {1'b0,OFFSET_k} + SIZE_k), compared in 33 bits so windows ending at 2^32 do not wrap. On overlap, the lowest index wins. No hit = unmapped.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE:
  - i_m_cyc && i_m_stb with a hit: latch sel_idx and the adjusted address, clear watchdog, go to ACTIVE.
  - Unmapped: go to RESP with err=1, data=ERR_DATA.
  - o_m_ack = 0 throughout.
- ACTIVE:
  - o_s_cyc/stb/we[sel_idx] = i_m_cyc/i_m_stb/i_m_we (combinational gating); all other slave strobes stay 0.
  - i_s_ack[sel_idx]: capture that slave's data, go to RESP with err=0.
  - Watchdog increments each cycle. When watchdog == TIMEOUT-1 with no ack (TIMEOUT != 0): go to RESP with err=1, data=ERR_DATA, and drop slave strobes.
  - i_m_cyc falls (abort): go to IDLE with no ack; slave strobes drop in the same cycle.
- RESP: o_m_ack = 1 for exactly one cycle; o_m_err and o_m_dat valid; slave strobes 0; next state IDLE. o_m_ack is cleared in IDLE.
- Latency: master stb to o_m_ack = slave ack latency + 2 cycles; unmapped = 2 cycles.
- Simultaneous slave ack and watchdog expiry: the ack wins (err=0).
- Master is WB classic and drops stb on the edge where it samples ack. A stb still high in IDLE is treated as a new transfer.
- o_m_dat holds its last value outside RESP.
- o_m_int follows the interrupt OR with 1-cycle latency, independent of FSM state.
- ADR_RELATIVE=1: o_s_adr = i_m_adr - OFFSET_sel_idx, modulo 2^32.

Decomposition:
- Shared package wb_mem_ic_pkg:
  - FSM state localparams (IDLE=2'd0, ACTIVE=2'd1, RESP=2'd2);
  - MAX_SLAVES=4;
  - default ERR_DATA;
  - watchdog width = clog2(TIMEOUT+1), minimum 1.
- One sub-module wb_mem_addr_decode: purely combinational window match. Inputs adr plus offset/size params; outputs hit and index.

Test Plan:
- Read slave 1 at 32'h0080_0010, slave acks after 3 cycles with 32'h1234_5678 -> o_s_stb[1] only, o_s_adr=32'h10, o_m_ack at cycle 5, o_m_dat=32'h1234_5678, o_m_err=0.
- Write to 32'h0100_0000 with NUM_SLAVES=2 (unmapped) -> no o_s_stb; o_m_ack+o_m_err 2 cycles later, o_m_dat=32'hDEAD_BEEF.
- TIMEOUT=8, slave 0 never acks -> o_s_stb[0] high 8 cycles then low; o_m_ack+o_m_err in the next cycle.
- Slave ack in the same cycle as watchdog expiry -> o_m_ack with o_m_err=0 and the slave's data.
- Master drops cyc in ACTIVE at cycle 2 -> slave strobes fall in the same cycle, no o_m_ack, FSM in IDLE, next transfer decodes normally.
- Assert rst mid-ACTIVE -> all outputs 0 immediately (async). i_s_int[1]=1 after reset -> o_m_int=1 one cycle later.
